// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up and the RISC-V divide special cases.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned W = XLEN;
  localparam logic [5:0] LastIter = 6'(W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             spec_q, spec_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W:0]       rem_q, rem_d;
  logic             done_q, done_d;
  logic [W-1:0]     result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;

  // Accept-time decode of the incoming request
  logic         a_signed_in, b_signed_in;
  logic         sa_in, sb_in;
  logic [W-1:0] mag_a_in, mag_b_in;
  logic         div_zero_in, div_ovf_in;

  always_comb begin
    a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa_in       = a_signed_in && rs1_data[W-1];
    sb_in       = b_signed_in && rs2_data[W-1];
    mag_a_in    = sa_in ? (~rs1_data + 1'b1) : rs1_data;
    mag_b_in    = sb_in ? (~rs2_data + 1'b1) : rs2_data;
    div_zero_in = funct3[2] && (rs2_data == '0);
    div_ovf_in  = funct3[2] && !funct3[0] &&
                  (rs1_data == {1'b1, {(W-1){1'b0}}}) && (rs2_data == '1);
  end

  // One iteration of each algorithm
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W+1:0]   rem_sh;
  logic [W+1:0]   rem_diff;
  logic           rem_take;

  always_comb begin
    // Multiplier sits in acc low half and shifts out LSB-first; product grows in high half.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    // Dividend shifts out of acc low half MSB-first into the partial remainder.
    rem_sh   = {rem_q, acc_q[W-1]};
    rem_diff = rem_sh - {2'b00, opb_q};
    rem_take = !rem_diff[W+1];
  end

  // Sign fix-up and result selection from the latched op
  logic [2*W-1:0] prod_signed;
  logic [W-1:0]   quo_signed;
  logic [W-1:0]   rem_signed;
  logic [W-1:0]   final_res;

  always_comb begin
    prod_signed = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
    quo_signed  = (sign_a_q ^ sign_b_q) ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem_signed  = sign_a_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];
    final_res   = '0;
    if (spec_q) begin
      final_res = acc_q[W-1:0];
    end else begin
      unique case (op_q)
        3'b000:                 final_res = prod_signed[W-1:0];
        3'b001, 3'b010, 3'b011: final_res = prod_signed[2*W-1:W];
        3'b100, 3'b101:         final_res = quo_signed;
        3'b110, 3'b111:         final_res = rem_signed;
        default:                final_res = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    spec_d   = spec_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = funct3;
          rd_d     = rd_in;
          sign_a_d = sa_in;
          sign_b_d = sb_in;
          opa_d    = mag_a_in;
          opb_d    = mag_b_in;
          cnt_d    = '0;
          rem_d    = '0;
          spec_d   = 1'b0;
          acc_d    = funct3[2] ? {{W{1'b0}}, mag_a_in} : {{W{1'b0}}, mag_b_in};
          state_d  = StCalc;
          if (div_zero_in) begin
            spec_d  = 1'b1;
            acc_d   = {{W{1'b0}}, (funct3[1] ? rs1_data : {W{1'b1}})};
            state_d = StDone;
          end else if (div_ovf_in) begin
            spec_d  = 1'b1;
            acc_d   = {{W{1'b0}}, (funct3[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}})};
            state_d = StDone;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[2]) begin
          rem_d = rem_take ? rem_diff[W:0] : rem_sh[W:0];
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], rem_take};
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d   = 1'b1;
        result_d = final_res;
        rd_out_d = rd_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      spec_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      spec_q   <= spec_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // busy covers the accept cycle through the last cycle before the done pulse
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops against a
// plain-arithmetic reference model, back-to-back, mid-operation reset and input noise.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ua64, ub64, p;
    logic signed [31:0] as, bs, r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    as   = a;
    bs   = b;
    p    = '0;
    r    = '0;
    case (f)
      3'b000: begin p = ua64 * ub64; r = p[31:0]; end
      3'b001: begin p = sa64 * sb64; r = p[63:32]; end
      3'b010: begin p = sa64 * ub64; r = p[63:32]; end
      3'b011: begin p = ua64 * ub64; r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = as / bs;
      end
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) r = as;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else r = as % bs;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 2;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after the accept edge; returns cycles from accept edge to done (bounded).
  task automatic wait_done(input bit garble, output int lat, output int busy_bad);
    lat      = 1;
    busy_bad = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_bad++;
      if (garble) begin
        start    = 1'($urandom_range(0, 1));
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_lat, input bit garble);
    int lat, busy_bad;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(garble, lat, busy_bad);
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, {27'b0, rd_out}, {27'b0, rd});
    check({tag, " busy_during"}, 32'(busy_bad), 32'd0);
    check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, " result_hold"}, result, exp);
  endtask

  initial begin
    int lat, busy_bad, seen_done;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;

    reset    = 1'b0;
    start    = 1'b0;
    funct3   = '0;
    rs1_data = '0;
    rs2_data = '0;
    rd_in    = '0;
    #12;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors; the first is driven into the first edge after reset release.
    do_op("mul_7x-3",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, 0);
    do_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 34, 0);
    do_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34, 0);
    do_op("mulhsu_-1x2", 3'b010, 32'hFFFF_FFFF, 32'd2,          5'd3,  32'hFFFF_FFFF, 34, 0);
    do_op("div_-7/2",    3'b100, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFD, 34, 1);
    do_op("rem_-7/2",    3'b110, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 34, 1);
    do_op("divu_100/7",  3'b101, 32'd100,        32'd7,          5'd0,  32'd14,        34, 0);
    do_op("remu_100/7",  3'b111, 32'd100,        32'd7,          5'd31, 32'd2,         34, 1);
    do_op("divu_5/0",    3'b101, 32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF, 2,  1);
    do_op("rem_5/0",     3'b110, 32'd5,          32'd0,          5'd8,  32'd5,         2,  0);
    do_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 2,  0);
    do_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         2,  1);

    // Start held high through a divide: one done for it, then the next op is taken.
    funct3   = 3'b101;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    rd_in    = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    funct3   = 3'b000;
    rs1_data = 32'd9;
    rs2_data = 32'd11;
    rd_in    = 5'd4;
    wait_done(0, lat, busy_bad);
    check("b2b first latency", 32'(lat), 32'd34);
    check("b2b first result", result, 32'd14);
    check("b2b first rd_out", {27'b0, rd_out}, 32'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b second accepted", {31'b0, busy}, 32'd1);
    wait_done(0, lat, busy_bad);
    check("b2b second latency", 32'(lat), 32'd34);
    check("b2b second result", result, 32'd99);
    check("b2b second rd_out", {27'b0, rd_out}, 32'd4);
    @(posedge clk);
    #1;

    // Randomized ops against the reference model, some with input noise while in flight.
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom);
      do_op($sformatf("rand%0d_f%0d", i, f), f, a, b, rd, ref_model(f, a, b),
            ref_latency(f, a, b), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a divide aborts it without a done pulse.
    funct3   = 3'b100;
    rs1_data = 32'h1234_5678;
    rs2_data = 32'd3;
    rd_in    = 5'd12;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort rd_out", {27'b0, rd_out}, 32'd0);
    seen_done = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    check("abort no_done", 32'(seen_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op("post_reset_mul_3x4", 3'b000, 32'd3, 32'd4, 5'd13, 32'd12, 34, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
